parity_engine: RTL and testbench
================================

PARITY_ENGINE -- requirements
Module: parity_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning frame data bits (legal 5..9).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning error-counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 PAR_EN  input  1  parity enable; 0 = no parity.
REQ-006 PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
REQ-007 start  input  1  begin serial accumulation; clears accumulator.
REQ-008 bit_valid  input  1  bit_in is a valid serial data bit this cycle.
REQ-009 bit_in  input  1  serial data bit.
REQ-010 load  input  1  parallel load of P_DATA; parity computed in one cycle.
REQ-011 P_DATA  input  DATA_WIDTH  parallel frame data.
REQ-012 chk_valid  input  1  rx_par_bit is the received parity bit to check.
REQ-013 rx_par_bit  input  1  received parity bit.
REQ-014 par_bit  output  1  computed parity bit, registered.
REQ-015 par_valid  output  1  par_bit is final; high throughout state READY.
REQ-016 par_err  output  1  one-cycle pulse on parity mismatch.
REQ-017 err_count  output  CNT_W  saturating mismatch count (see Configuration).

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM, READY.
REQ-019 PAR_EN and PAR_TYP SHALL be captured on the cycle start or load is accepted and held until the next start/load.
REQ-020 Final parity SHALL be: even = XOR of data bits; odd = XNOR; mark = 1; space = 0; PAR_EN=0 -> 0.
REQ-021 IDLE: start -> ACCUM, accumulator = 0, bit counter = 0; else load -> READY with par_bit from P_DATA; start has priority over load.
REQ-022 ACCUM: each bit_valid cycle SHALL XOR bit_in into the accumulator and increment the counter; bit_valid on count DATA_WIDTH-1 -> READY, par_valid high the following cycle.
REQ-023 ACCUM: cycles without bit_valid SHALL hold state; start SHALL restart accumulation (counter and accumulator cleared); load SHALL be ignored.
REQ-024 READY: par_bit and par_valid SHALL hold until chk_valid, start or load.
REQ-025 READY + chk_valid: if PAR_EN=1 and rx_par_bit != par_bit, par_err SHALL pulse high for exactly the next cycle; FSM -> IDLE; par_valid drops the same next cycle.
REQ-026 chk_valid with PAR_EN captured 0 SHALL never assert par_err.
REQ-027 chk_valid outside READY SHALL be ignored (no par_err, no count).
REQ-028 READY: start (priority) -> ACCUM; load -> recompute, remain READY; either takes priority over chk_valid in the same cycle, which is discarded.
REQ-029 Parallel load latency SHALL be 1 cycle (load edge -> par_valid high); serial latency 1 cycle after the last bit_valid.

Reset
REQ-030 On rst low, asynchronously: state IDLE, par_bit 0, par_valid 0, par_err 0, err_count 0, accumulator/counter/captured mode 0.
REQ-031 Reset mid-ACCUM or mid-READY SHALL discard the frame; no par_err after release.

Configuration
REQ-032 Macro PARITY_ERR_CNT_EN SHALL control the error counter.
REQ-033 With PARITY_ERR_CNT_EN defined: err_count SHALL increment on every par_err pulse and saturate at 2^CNT_W-1 without wrap.
REQ-034 Without it: err_count SHALL be tied to 0 and no counter flops SHALL be synthesised.

Verification
REQ-035 Parallel even: PAR_EN=1, PAR_TYP=00, load P_DATA=8'hA5 -> next cycle par_valid=1, par_bit=0.
REQ-036 Parallel odd: PAR_TYP=01, load 8'h07 -> par_bit=0; load 8'h03 -> par_bit=1.
REQ-037 Serial even: start, 8 bit_valid bits 1,0,1,1,0,0,0,0 with 2 idle gaps -> par_valid one cycle after 8th bit, par_bit=1.
REQ-038 Check: READY with par_bit=1, chk_valid with rx_par_bit=0 -> par_err one cycle, err_count 0->1, state IDLE; rx_par_bit=1 -> no par_err.
REQ-039 Saturation (PARITY_ERR_CNT_EN, CNT_W=2): 5 mismatching checks -> err_count 1,2,3,3,3.
REQ-040 Abort: start mid-ACCUM after 4 bits, then 8 fresh bits 8'hFF with mark mode -> par_bit=1; rst low in READY -> all outputs 0 immediately.

Source files
------------

// File: rtl/parity_engine.sv
// Parity generator/checker with parallel-load and serial-accumulate paths.
// Optional saturating mismatch counter enabled by defining PARITY_ERR_CNT_EN.
module parity_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  start,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  chk_valid,
  input  logic                  rx_par_bit,
  output logic                  par_bit,
  output logic                  par_valid,
  output logic                  par_err,
  output logic [CNT_W-1:0]      err_count
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StReady
  } state_e;

  state_e               state_q, state_d;
  logic                 acc_q, acc_d;
  logic [BitCntW-1:0]   cnt_q, cnt_d;
  logic                 par_en_q, par_en_d;
  logic [1:0]           par_typ_q, par_typ_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;

  // Maps the XOR of the data bits onto the line parity for the selected mode.
  function automatic logic final_parity(input logic en, input logic [1:0] typ, input logic x);
    logic p;
    p = 1'b0;
    if (en) begin
      unique case (typ)
        2'b00:   p = x;
        2'b01:   p = ~x;
        2'b10:   p = 1'b1;
        default: p = 1'b0;
      endcase
    end
    return p;
  endfunction

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bit_d = par_bit_q;
    par_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StAccum;
          acc_d     = 1'b0;
          cnt_d     = '0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end else if (load) begin
          state_d   = StReady;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bit_d = final_parity(PAR_EN, PAR_TYP, ^P_DATA);
        end
      end

      StAccum: begin
        if (start) begin
          acc_d     = 1'b0;
          cnt_d     = '0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end else if (bit_valid) begin
          acc_d = acc_q ^ bit_in;
          if (cnt_q == LastBit) begin
            state_d   = StReady;
            cnt_d     = '0;
            par_bit_d = final_parity(par_en_q, par_typ_q, acc_q ^ bit_in);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StReady: begin
        // start and load both pre-empt a same-cycle check, which is dropped.
        if (start) begin
          state_d   = StAccum;
          acc_d     = 1'b0;
          cnt_d     = '0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end else if (load) begin
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bit_d = final_parity(PAR_EN, PAR_TYP, ^P_DATA);
        end else if (chk_valid) begin
          state_d   = StIdle;
          par_err_d = par_en_q && (rx_par_bit != par_bit_q);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 2'b00;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_bit   = par_bit_q;
  assign par_valid = (state_q == StReady);
  assign par_err   = par_err_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Counts on par_err_d so the count moves on the same edge the pulse appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (par_err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_engine.sv
// Directed-plus-random bench for parity_engine against a frame-level parity model.
module tb_parity_engine;

`ifdef PARITY_ERR_CNT_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 8;
`endif
  localparam int unsigned DATA_WIDTH = 8;
  localparam int CntMax = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  PAR_EN;
  logic [1:0]            PAR_TYP;
  logic                  start;
  logic                  bit_valid;
  logic                  bit_in;
  logic                  load;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  chk_valid;
  logic                  rx_par_bit;
  logic                  par_bit;
  logic                  par_valid;
  logic                  par_err;
  logic [CNT_W-1:0]      err_count;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: is a result pending, what it is, whether parity was on, error total.
  bit m_ready = 1'b0;
  bit m_par   = 1'b0;
  bit m_en    = 1'b0;
  int m_errs  = 0;

  parity_engine #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .start     (start),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .load      (load),
    .P_DATA    (P_DATA),
    .chk_valid (chk_valid),
    .rx_par_bit(rx_par_bit),
    .par_bit   (par_bit),
    .par_valid (par_valid),
    .par_err   (par_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic bit ref_parity(input bit en, input int typ, input int ones);
    if (!en) return 1'b0;
    case (typ)
      0:       return (ones % 2) == 1;
      1:       return (ones % 2) == 0;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_count();
`ifdef PARITY_ERR_CNT_EN
    return m_errs;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] data, input bit en, input logic [1:0] typ);
    load = 1'b1; P_DATA = data; PAR_EN = en; PAR_TYP = typ;
    tick();
    load = 1'b0;
    m_en    = en;
    m_par   = ref_parity(en, int'(typ), $countones(data));
    m_ready = 1'b1;
    check("load_valid", 32'(par_valid), 32'd1);
    check("load_bit", 32'(par_bit), 32'(m_par));
  endtask

  task automatic do_check(input bit rx);
    bit exp_err;
    chk_valid = 1'b1; rx_par_bit = rx;
    tick();
    chk_valid = 1'b0;
    exp_err = m_ready && m_en && (rx != m_par);
    if (exp_err && m_errs < CntMax) m_errs++;
    m_ready = 1'b0;
    check("chk_err", 32'(par_err), 32'(exp_err));
    check("chk_valid_drop", 32'(par_valid), 32'd0);
    check("chk_count", 32'(err_count), 32'(exp_count()));
    tick();
    check("err_pulse_end", 32'(par_err), 32'd0);
  endtask

  // Sends data LSB first; gap_mask bit i inserts one idle cycle (with a stray load) before bit i.
  task automatic do_serial(input logic [7:0] data, input bit en, input logic [1:0] typ,
                           input logic [7:0] gap_mask);
    start = 1'b1; PAR_EN = en; PAR_TYP = typ;
    tick();
    start = 1'b0;
    check("ser_start", 32'(par_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (gap_mask[i]) begin
        load = 1'b1; P_DATA = 8'($urandom);
        tick();
        load = 1'b0;
        check("ser_gap", 32'(par_valid), 32'd0);
      end
      bit_valid = 1'b1; bit_in = data[i];
      tick();
      bit_valid = 1'b0;
      if (i < 7) check("ser_early", 32'(par_valid), 32'd0);
    end
    m_en    = en;
    m_par   = ref_parity(en, int'(typ), $countones(data));
    m_ready = 1'b1;
    check("ser_valid", 32'(par_valid), 32'd1);
    check("ser_bit", 32'(par_bit), 32'(m_par));
  endtask

  initial begin
    rst = 1'b0; PAR_EN = 1'b0; PAR_TYP = 2'b00; start = 1'b0; bit_valid = 1'b0;
    bit_in = 1'b0; load = 1'b0; P_DATA = '0; chk_valid = 1'b0; rx_par_bit = 1'b0;
    #12;
    check("rst_valid", 32'(par_valid), 32'd0);
    check("rst_bit", 32'(par_bit), 32'd0);
    check("rst_err", 32'(par_err), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    rst = 1'b1;
    tick();

    // Parallel even / odd
    do_load(8'hA5, 1'b1, 2'b00);
    check("even_A5", 32'(par_bit), 32'd0);
    do_load(8'h07, 1'b1, 2'b01);
    check("odd_07", 32'(par_bit), 32'd0);
    do_load(8'h03, 1'b1, 2'b01);
    check("odd_03", 32'(par_bit), 32'd1);

    // Mismatch then match
    do_check(1'b0);
    check("req038_count", 32'(err_count), 32'(exp_count()));
    do_load(8'h03, 1'b1, 2'b01);
    do_check(1'b1);

    // Check outside READY is ignored
    do_check(1'b1);

    // Serial even with two gaps: bits 1,0,1,1,0,0,0,0
    do_serial(8'b0000_1101, 1'b1, 2'b00, 8'b0001_0100);
    check("ser_even", 32'(par_bit), 32'd1);

    // load + chk in READY: check discarded, recompute
    load = 1'b1; P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 2'b00;
    chk_valid = 1'b1; rx_par_bit = 1'b0;
    tick();
    load = 1'b0; chk_valid = 1'b0;
    m_par = 1'b1; m_en = 1'b1;
    check("ld_chk_err", 32'(par_err), 32'd0);
    check("ld_chk_valid", 32'(par_valid), 32'd1);
    check("ld_chk_bit", 32'(par_bit), 32'd1);

    // start + chk in READY: check discarded, go accumulate
    start = 1'b1; chk_valid = 1'b1; rx_par_bit = 1'b0;
    tick();
    start = 1'b0; chk_valid = 1'b0;
    m_ready = 1'b0;
    check("st_chk_err", 32'(par_err), 32'd0);
    check("st_chk_valid", 32'(par_valid), 32'd0);

    // Abort after 4 bits, then 8 fresh bits in mark mode
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    check("abort_mid", 32'(par_valid), 32'd0);
    do_serial(8'hFF, 1'b1, 2'b10, 8'h00);
    check("mark_ff", 32'(par_bit), 32'd1);

    // Async reset in READY
    #2 rst = 1'b0;
    #1;
    m_ready = 1'b0; m_errs = 0;
    check("arst_valid", 32'(par_valid), 32'd0);
    check("arst_bit", 32'(par_bit), 32'd0);
    check("arst_err", 32'(par_err), 32'd0);
    check("arst_count", 32'(err_count), 32'd0);
    #3 rst = 1'b1;
    chk_valid = 1'b1; rx_par_bit = 1'b1;
    tick();
    chk_valid = 1'b0;
    check("post_rst_err", 32'(par_err), 32'd0);
    check("post_rst_valid", 32'(par_valid), 32'd0);

    // start has priority over load in IDLE
    start = 1'b1; load = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 2'b00;
    tick();
    start = 1'b0; load = 1'b0;
    check("idle_prio", 32'(par_valid), 32'd0);
    do_serial(8'h80, 1'b1, 2'b00, 8'h00);

    // Parity disabled never flags
    do_load(8'h5A, 1'b0, 2'b10);
    do_check(1'b1);

    // Five mismatches: saturates when the counter is present
    for (int i = 0; i < 5; i++) begin
      do_load(8'h03, 1'b1, 2'b01);
      do_check(1'b0);
    end

    // Random frames
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic [1:0] t;
      bit         e;
      d = 8'($urandom);
      t = 2'($urandom_range(0, 3));
      e = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) do_load(d, e, t);
      else do_serial(d, e, t, 8'($urandom));
      do_check(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
